// File: rtl/operand_collector.sv
// Operand collector: per-entry staging of up to two RF source operands,
// with round-robin dispatch of complete entries to the execution unit.
module operand_collector #(
  parameter int NUM_OC = 8,
  parameter int DATA_W = 256,
  parameter int WARP_W = 3,
  parameter int OP_W   = 5,
  parameter int ROW_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  output logic [2:0]        alloc_idx,
  input  logic [WARP_W-1:0] alloc_warp,
  input  logic [OP_W-1:0]   alloc_opcode,
  input  logic [ROW_W-1:0]  alloc_dst_row,
  input  logic              alloc_two_src,
  input  logic              rf_rd_valid,
  input  logic [3:0]        rf_rd_ocid,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [2:0]        disp_idx,
  output logic [WARP_W-1:0] disp_warp,
  output logic [OP_W-1:0]   disp_opcode,
  output logic [ROW_W-1:0]  disp_dst_row,
  output logic [DATA_W-1:0] disp_src1,
  output logic [DATA_W-1:0] disp_src2,
  output logic [3:0]        free_cnt,
  output logic              err_stray
);

  typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_ISSUED} oc_state_e;

  oc_state_e         state_q [NUM_OC];
  oc_state_e         state_d [NUM_OC];
  logic [1:0]        need_q  [NUM_OC];
  logic [1:0]        need_d  [NUM_OC];
  logic [WARP_W-1:0] warp_q  [NUM_OC];
  logic [OP_W-1:0]   op_q    [NUM_OC];
  logic [ROW_W-1:0]  dst_q   [NUM_OC];
  logic              two_q   [NUM_OC];
  logic [DATA_W-1:0] src1_q  [NUM_OC];
  logic [DATA_W-1:0] src2_q  [NUM_OC];

  logic [2:0]        rr_ptr;
  logic [NUM_OC-1:0] free_vec;
  logic [NUM_OC-1:0] elig_vec;
  logic              alloc_fire;
  logic              disp_fire;
  logic              rf_slot;
  logic [2:0]        rf_idx;
  logic              rf_hit;
  logic              arb_load;
  logic              pick_found;
  logic [2:0]        pick_idx;
  logic [2:0]        rr_next;
  logic [3:0]        scan_sum;
  logic [2:0]        scan_idx;
  logic [3:0]        free_nxt;

  // An entry whose last operand landed on the previous edge is already
  // eligible, so it dispatches on the same edge it would turn READY.
  always_comb begin
    free_vec = '0;
    elig_vec = '0;
    for (int i = 0; i < NUM_OC; i++) begin
      free_vec[i] = (state_q[i] == S_FREE);
      elig_vec[i] = (state_q[i] == S_READY) ||
                    ((state_q[i] == S_WAIT) && (need_q[i] == 2'b00));
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_OC - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = 3'(i);
    end
  end

  assign alloc_ready = |free_vec;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign disp_fire   = disp_valid && disp_ready;

  assign rf_slot = rf_rd_ocid[3];
  assign rf_idx  = rf_rd_ocid[2:0];
  assign rf_hit  = rf_rd_valid && ({1'b0, rf_idx} < 4'(NUM_OC)) &&
                   (state_q[rf_idx] == S_WAIT) && need_q[rf_idx][rf_slot];

  // Round-robin scan: first eligible entry at or after rr_ptr, wrapping.
  always_comb begin
    arb_load   = !disp_valid || disp_ready;
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int k = 0; k < NUM_OC; k++) begin
      scan_sum = {1'b0, rr_ptr} + 4'(k);
      if (scan_sum >= 4'(NUM_OC)) scan_sum = scan_sum - 4'(NUM_OC);
      scan_idx = scan_sum[2:0];
      if (!pick_found && elig_vec[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
    rr_next = (pick_idx == 3'(NUM_OC - 1)) ? 3'd0 : pick_idx + 3'd1;
  end

  // NOTE: combinational next-state logic copies the current state first so
  // every path assigns every element and no latch can be inferred.
  always_comb begin
    for (int i = 0; i < NUM_OC; i++) begin
      state_d[i] = state_q[i];
      need_d[i]  = need_q[i];
      if ((state_q[i] == S_WAIT) && (need_q[i] == 2'b00)) state_d[i] = S_READY;
    end
    if (alloc_fire) begin
      state_d[alloc_idx] = S_WAIT;
      need_d[alloc_idx]  = {alloc_two_src, 1'b1};
    end
    if (rf_hit) need_d[rf_idx][rf_slot] = 1'b0;
    if (disp_fire) state_d[disp_idx] = S_FREE;
    if (arb_load && pick_found) state_d[pick_idx] = S_ISSUED;
  end

  always_comb begin
    free_nxt = '0;
    for (int i = 0; i < NUM_OC; i++) begin
      free_nxt = free_nxt + 4'(state_d[i] == S_FREE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_OC; i++) begin
        state_q[i] <= S_FREE;
        need_q[i]  <= 2'b00;
      end
      rr_ptr     <= '0;
      disp_valid <= 1'b0;
      disp_idx   <= '0;
      free_cnt   <= 4'(NUM_OC);
      err_stray  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OC; i++) begin
        state_q[i] <= state_d[i];
        need_q[i]  <= need_d[i];
      end
      if (arb_load) begin
        disp_valid <= pick_found;
        disp_idx   <= pick_found ? pick_idx : 3'd0;
        if (pick_found) rr_ptr <= rr_next;
      end
      free_cnt <= free_nxt;
      if (rf_rd_valid && !rf_hit) err_stray <= 1'b1;
    end
  end

  // NOTE: payload storage has no reset; entry state and need masks gate
  // every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      warp_q[alloc_idx] <= alloc_warp;
      op_q[alloc_idx]   <= alloc_opcode;
      dst_q[alloc_idx]  <= alloc_dst_row;
      two_q[alloc_idx]  <= alloc_two_src;
    end
    if (rf_hit) begin
      if (rf_slot) src2_q[rf_idx] <= rf_rd_data;
      else         src1_q[rf_idx] <= rf_rd_data;
    end
  end

  // The issued entry cannot be written until freed, so the bundle is stable
  // for as long as the consumer stalls.
  assign disp_warp    = disp_valid ? warp_q[disp_idx] : '0;
  assign disp_opcode  = disp_valid ? op_q[disp_idx]   : '0;
  assign disp_dst_row = disp_valid ? dst_q[disp_idx]  : '0;
  assign disp_src1    = disp_valid ? src1_q[disp_idx] : '0;
  assign disp_src2    = (disp_valid && two_q[disp_idx]) ? src2_q[disp_idx] : '0;

endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector: allocation, operand return, stray
// detection, round-robin dispatch, back-pressure and asynchronous reset.
module tb_operand_collector;

  logic         clk;
  logic         rst;
  logic         alloc_valid;
  logic         alloc_ready;
  logic [2:0]   alloc_idx;
  logic [2:0]   alloc_warp;
  logic [4:0]   alloc_opcode;
  logic [2:0]   alloc_dst_row;
  logic         alloc_two_src;
  logic         rf_rd_valid;
  logic [3:0]   rf_rd_ocid;
  logic [255:0] rf_rd_data;
  logic         disp_valid;
  logic         disp_ready;
  logic [2:0]   disp_idx;
  logic [2:0]   disp_warp;
  logic [4:0]   disp_opcode;
  logic [2:0]   disp_dst_row;
  logic [255:0] disp_src1;
  logic [255:0] disp_src2;
  logic [3:0]   free_cnt;
  logic         err_stray;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  localparam logic [255:0] DATA_A = {8{32'hA1A2A3A4}};
  localparam logic [255:0] DATA_B = {8{32'hB1B2B3B4}};
  localparam logic [255:0] DATA_C = {8{32'hC0FFEE01}};
  localparam logic [255:0] DATA_D = {8{32'hDEAD0D0D}};

  operand_collector #(
    .NUM_OC(8), .DATA_W(256), .WARP_W(3), .OP_W(5), .ROW_W(3)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .alloc_warp(alloc_warp), .alloc_opcode(alloc_opcode),
    .alloc_dst_row(alloc_dst_row), .alloc_two_src(alloc_two_src),
    .rf_rd_valid(rf_rd_valid), .rf_rd_ocid(rf_rd_ocid), .rf_rd_data(rf_rd_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_idx(disp_idx),
    .disp_warp(disp_warp), .disp_opcode(disp_opcode), .disp_dst_row(disp_dst_row),
    .disp_src1(disp_src1), .disp_src2(disp_src2),
    .free_cnt(free_cnt), .err_stray(err_stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [255:0] mk(input int i);
    logic [7:0] b;
    b = 8'(i * 37 + 11);
    return {32{b}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    alloc_valid = 1'b0;
    rf_rd_valid = 1'b0;
    disp_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic do_alloc(input logic two, input logic [2:0] w,
                          input logic [4:0] op, input logic [2:0] dst);
    alloc_valid = 1'b1;
    alloc_two_src = two;
    alloc_warp = w;
    alloc_opcode = op;
    alloc_dst_row = dst;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic rf_ret(input logic [3:0] ocid, input logic [255:0] d);
    rf_rd_valid = 1'b1;
    rf_rd_ocid = ocid;
    rf_rd_data = d;
    step();
    rf_rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    chk_cnt++;
    if ({free_cnt, alloc_ready, alloc_idx, disp_valid, err_stray, disp_idx} !==
        {4'd8, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0})
      $display("FAIL reset_state: free_cnt=%0d alloc_ready=%b alloc_idx=%0d disp_valid=%b err=%b disp_idx=%0d, expected 8 1 0 0 0 0",
               free_cnt, alloc_ready, alloc_idx, disp_valid, err_stray, disp_idx);
    else pass_cnt++;
    chk_cnt++;
    if ({disp_warp, disp_opcode, disp_dst_row, disp_src1, disp_src2} !== '0)
      $display("FAIL reset_disp_zero: warp=%0d op=%0d dst=%0d src1=%h", disp_warp, disp_opcode, disp_dst_row, disp_src1);
    else pass_cnt++;
    rst = 1'b1;
    step();
    chk_cnt++;
    if (free_cnt !== 4'd8 || alloc_ready !== 1'b1)
      $display("FAIL reset_release: free_cnt=%0d alloc_ready=%b, expected 8 1", free_cnt, alloc_ready);
    else pass_cnt++;
  endtask

  task automatic test_two_src();
    chk_cnt++;
    if (alloc_idx !== 3'd0) $display("FAIL two_src_alloc_idx: got %0d expected 0", alloc_idx);
    else pass_cnt++;
    do_alloc(1'b1, 3'd2, 5'd5, 3'd3);
    chk_cnt++;
    if (free_cnt !== 4'd7 || alloc_idx !== 3'd1)
      $display("FAIL two_src_free_cnt: free_cnt=%0d alloc_idx=%0d, expected 7 1", free_cnt, alloc_idx);
    else pass_cnt++;
    rf_ret(4'h0, DATA_A);
    rf_ret(4'h8, DATA_B);
    chk_cnt++;
    if (disp_valid !== 1'b0) $display("FAIL two_src_early_valid: got %b expected 0", disp_valid);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({disp_valid, disp_idx, disp_warp, disp_opcode, disp_dst_row} !== {1'b1, 3'd0, 3'd2, 5'd5, 3'd3})
      $display("FAIL two_src_bundle: valid=%b idx=%0d warp=%0d op=%0d dst=%0d, expected 1 0 2 5 3",
               disp_valid, disp_idx, disp_warp, disp_opcode, disp_dst_row);
    else pass_cnt++;
    chk_cnt++;
    if (disp_src1 !== DATA_A || disp_src2 !== DATA_B)
      $display("FAIL two_src_data: src1=%h src2=%h", disp_src1, disp_src2);
    else pass_cnt++;
    disp_ready = 1'b1;
    step();
    disp_ready = 1'b0;
    chk_cnt++;
    if (free_cnt !== 4'd8 || disp_valid !== 1'b0 || disp_src1 !== '0)
      $display("FAIL two_src_free: free_cnt=%0d disp_valid=%b src1=%h, expected 8 0 0", free_cnt, disp_valid, disp_src1);
    else pass_cnt++;
  endtask

  task automatic test_single_stray();
    chk_cnt++;
    if (err_stray !== 1'b0) $display("FAIL stray_initial: got %b expected 0", err_stray);
    else pass_cnt++;
    do_alloc(1'b0, 3'd1, 5'd7, 3'd4);
    rf_ret(4'h0, DATA_C);
    rf_ret(4'h8, DATA_D);
    chk_cnt++;
    if (err_stray !== 1'b1) $display("FAIL stray_set: got %b expected 1", err_stray);
    else pass_cnt++;
    chk_cnt++;
    if ({disp_valid, disp_idx, disp_warp, disp_opcode, disp_dst_row} !== {1'b1, 3'd0, 3'd1, 5'd7, 3'd4} ||
        disp_src1 !== DATA_C || disp_src2 !== '0)
      $display("FAIL single_src_bundle: valid=%b idx=%0d warp=%0d op=%0d dst=%0d src1=%h src2=%h",
               disp_valid, disp_idx, disp_warp, disp_opcode, disp_dst_row, disp_src1, disp_src2);
    else pass_cnt++;
    disp_ready = 1'b1;
    step();
    disp_ready = 1'b0;
    chk_cnt++;
    if (err_stray !== 1'b1 || free_cnt !== 4'd8 || disp_valid !== 1'b0)
      $display("FAIL stray_sticky: err=%b free_cnt=%0d disp_valid=%b, expected 1 8 0", err_stray, free_cnt, disp_valid);
    else pass_cnt++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      chk_cnt++;
      if (alloc_idx !== 3'(i) || alloc_ready !== 1'b1)
        $display("FAIL full_alloc_idx: alloc_idx=%0d alloc_ready=%b, expected %0d 1", alloc_idx, alloc_ready, i);
      else pass_cnt++;
      do_alloc(1'b1, 3'(i), 5'(i), 3'(i));
    end
    chk_cnt++;
    if (free_cnt !== 4'd0 || alloc_ready !== 1'b0)
      $display("FAIL full_state: free_cnt=%0d alloc_ready=%b, expected 0 0", free_cnt, alloc_ready);
    else pass_cnt++;
    alloc_valid = 1'b1;
    alloc_two_src = 1'b0;
    alloc_warp = 3'd7;
    alloc_opcode = 5'd31;
    alloc_dst_row = 3'd7;
    step();
    alloc_valid = 1'b0;
    chk_cnt++;
    if (free_cnt !== 4'd0 || alloc_ready !== 1'b0 || disp_valid !== 1'b0)
      $display("FAIL full_ignored_alloc: free_cnt=%0d alloc_ready=%b disp_valid=%b, expected 0 0 0",
               free_cnt, alloc_ready, disp_valid);
    else pass_cnt++;
    rf_ret(4'h5, mk(5));
    rf_ret(4'hD, ~mk(5));
    step();
    chk_cnt++;
    if ({disp_valid, disp_idx, disp_warp, disp_opcode, disp_dst_row} !== {1'b1, 3'd5, 3'd5, 5'd5, 3'd5} ||
        disp_src1 !== mk(5) || disp_src2 !== ~mk(5))
      $display("FAIL full_dispatch5: valid=%b idx=%0d warp=%0d op=%0d dst=%0d src1=%h src2=%h",
               disp_valid, disp_idx, disp_warp, disp_opcode, disp_dst_row, disp_src1, disp_src2);
    else pass_cnt++;
    disp_ready = 1'b1;
    step();
    disp_ready = 1'b0;
    chk_cnt++;
    if (alloc_ready !== 1'b1 || alloc_idx !== 3'd5 || free_cnt !== 4'd1)
      $display("FAIL full_refree: alloc_ready=%b alloc_idx=%0d free_cnt=%0d, expected 1 5 1",
               alloc_ready, alloc_idx, free_cnt);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int seq_a [3] = '{1, 3, 6};
    int seq_b [4] = '{7, 0, 2, 5};
    int data_b [4] = '{7, 9, 2, 5};
    int warp_b [4] = '{7, 4, 2, 5};
    apply_reset();
    for (int i = 0; i < 8; i++) do_alloc(1'b0, 3'(i), 5'(i + 8), 3'(7 - i));
    rf_ret(4'h0, mk(0));
    rf_ret(4'h1, mk(1));
    chk_cnt++;
    if (disp_valid !== 1'b1 || disp_idx !== 3'd0)
      $display("FAIL rr_first: valid=%b idx=%0d, expected 1 0", disp_valid, disp_idx);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      if (k == 0)      rf_ret(4'h3, mk(3));
      else if (k == 1) rf_ret(4'h6, mk(6));
      else             step();
      chk_cnt++;
      if (disp_valid !== 1'b1 || disp_idx !== 3'd0 || disp_warp !== 3'd0 || disp_src1 !== mk(0))
        $display("FAIL hold0_cycle%0d: valid=%b idx=%0d warp=%0d src1=%h, expected idx 0 stable",
                 k, disp_valid, disp_idx, disp_warp, disp_src1);
      else pass_cnt++;
    end
    disp_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk_cnt++;
      if ({disp_valid, disp_idx, disp_warp, disp_opcode} !== {1'b1, 3'(seq_a[n]), 3'(seq_a[n]), 5'(seq_a[n] + 8)} ||
          disp_src1 !== mk(seq_a[n]) || disp_src2 !== '0)
        $display("FAIL rr_order_a%0d: valid=%b idx=%0d warp=%0d op=%0d, expected idx %0d",
                 n, disp_valid, disp_idx, disp_warp, disp_opcode, seq_a[n]);
      else pass_cnt++;
    end
    disp_ready = 1'b0;
    chk_cnt++;
    if (alloc_idx !== 3'd0) $display("FAIL rr_realloc_idx: got %0d expected 0", alloc_idx);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: do_alloc(1'b0, 3'd4, 5'd20, 3'd1);
        1: rf_ret(4'h5, mk(5));
        2: rf_ret(4'h2, mk(2));
        3: rf_ret(4'h7, mk(7));
        default: rf_ret(4'h0, mk(9));
      endcase
      chk_cnt++;
      if (disp_valid !== 1'b1 || disp_idx !== 3'd6 || disp_warp !== 3'd6 || disp_src1 !== mk(6))
        $display("FAIL hold6_cycle%0d: valid=%b idx=%0d warp=%0d src1=%h, expected idx 6 stable",
                 k, disp_valid, disp_idx, disp_warp, disp_src1);
      else pass_cnt++;
    end
    disp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      chk_cnt++;
      if ({disp_valid, disp_idx, disp_warp} !== {1'b1, 3'(seq_b[n]), 3'(warp_b[n])} ||
          disp_src1 !== mk(data_b[n]))
        $display("FAIL rr_order_b%0d: valid=%b idx=%0d warp=%0d, expected idx %0d warp %0d",
                 n, disp_valid, disp_idx, disp_warp, seq_b[n], warp_b[n]);
      else pass_cnt++;
    end
    step();
    disp_ready = 1'b0;
    chk_cnt++;
    if (disp_valid !== 1'b0 || free_cnt !== 4'd7)
      $display("FAIL rr_drain: valid=%b free_cnt=%0d, expected 0 7", disp_valid, free_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 4; i++) do_alloc(1'b1, 3'(i), 5'(i), 3'(i));
    rf_ret(4'h0, mk(0));
    rf_ret(4'h8, ~mk(0));
    step();
    chk_cnt++;
    if (disp_valid !== 1'b1 || disp_idx !== 3'd0 || free_cnt !== 4'd4)
      $display("FAIL mid_pre: valid=%b idx=%0d free_cnt=%0d, expected 1 0 4", disp_valid, disp_idx, free_cnt);
    else pass_cnt++;
    #2;
    rst = 1'b0;
    #1;
    chk_cnt++;
    if ({disp_valid, free_cnt, alloc_ready, alloc_idx, disp_warp} !== {1'b0, 4'd8, 1'b1, 3'd0, 3'd0} ||
        disp_src1 !== '0)
      $display("FAIL mid_reset_immediate: valid=%b free_cnt=%0d alloc_ready=%b alloc_idx=%0d warp=%0d",
               disp_valid, free_cnt, alloc_ready, alloc_idx, disp_warp);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_cnt++;
    if (err_stray !== 1'b0 || free_cnt !== 4'd8)
      $display("FAIL mid_after_release: err=%b free_cnt=%0d, expected 0 8", err_stray, free_cnt);
    else pass_cnt++;
    rf_ret(4'h2, mk(2));
    chk_cnt++;
    if (err_stray !== 1'b1 || disp_valid !== 1'b0 || free_cnt !== 4'd8)
      $display("FAIL mid_old_ocid_stray: err=%b valid=%b free_cnt=%0d, expected 1 0 8", err_stray, disp_valid, free_cnt);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0;
    alloc_valid = 1'b0;
    alloc_warp = '0;
    alloc_opcode = '0;
    alloc_dst_row = '0;
    alloc_two_src = 1'b0;
    rf_rd_valid = 1'b0;
    rf_rd_ocid = '0;
    rf_rd_data = '0;
    disp_ready = 1'b0;
    test_reset();
    test_two_src();
    test_single_stray();
    test_full();
    test_round_robin();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/operand_collector.md
Name: operand_collector

Overview:
- Downstream consumer of the register-file read requests tagged by the request FIFO.
- Holds NUM_OC operand-collector entries. Each entry is allocated at issue, receives up to two 256-bit source operands returned by the RF (tagged with a 4-bit ocid), and becomes ready when all needed operands are present.
- A round-robin arbiter dispatches ready entries to the execution unit over a valid/ready handshake, then frees the entry.

Parameters:
- NUM_OC, 8, number of collector entries; max 8 because the ocid index field is 3 bits.
- DATA_W, 256, operand width; matches the RF row and CDB width.
- WARP_W, 3, warp ID width.
- OP_W, 5, opcode width.
- ROW_W, 3, destination physical row width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  issue stage requests an entry.
- alloc_ready  out  1  at least one FREE entry exists (combinational).
- alloc_idx  out  3  index of the entry that will be granted (lowest-index FREE entry; combinational).
- alloc_warp  in  WARP_W  warp ID.
- alloc_opcode  in  OP_W  opcode.
- alloc_dst_row  in  ROW_W  destination physical row.
- alloc_two_src  in  1  1 = two sources needed, 0 = src1 only.
- rf_rd_valid  in  1  RF read data valid this cycle.
- rf_rd_ocid  in  4  bit3 = slot (0 = src1, 1 = src2); bits[2:0] = entry index.
- rf_rd_data  in  DATA_W  operand data.
- disp_valid  out  1  dispatch bundle valid (registered).
- disp_ready  in  1  execution unit accepts the bundle.
- disp_idx  out  3  entry index being dispatched.
- disp_warp  out  WARP_W  warp ID of the dispatched entry.
- disp_opcode  out  OP_W  opcode of the dispatched entry.
- disp_dst_row  out  ROW_W  destination row of the dispatched entry.
- disp_src1  out  DATA_W  source 1 operand.
- disp_src2  out  DATA_W  source 2 operand.
- free_cnt  out  4  number of FREE entries.
- err_stray  out  1  sticky error flag: an RF return did not match a needed slot.

Behaviour:
- Reset (asynchronous, rst=0): all entries FREE, need masks 0, rr_ptr=0, disp_valid=0, err_stray=0. Consequently free_cnt=NUM_OC and alloc_ready=1. Operand storage is not cleared.
- disp_warp, disp_opcode, disp_dst_row, disp_src1, disp_src2 and disp_idx are forced to 0 whenever disp_valid=0.
- Per-entry states: FREE -> WAIT -> READY -> ISSUED -> FREE.
- Allocation: on alloc_valid & alloc_ready, entry[alloc_idx] goes to WAIT with need={alloc_two_src,1}, and warp, opcode and dst_row are latched. If alloc_ready=0, alloc_valid is ignored.
- Operand return: on rf_rd_valid, if entry[idx] is in WAIT and need[slot]=1, the data is written to that slot and need[slot] is cleared. Otherwise the data is dropped and err_stray is set.
- WAIT -> READY on the cycle after need becomes 0. For single-source entries, disp_src2 = 0.
- Arbiter: a new selection loads when disp_valid=0 or (disp_valid & disp_ready).
  - It searches READY entries starting at rr_ptr, wrapping modulo NUM_OC.
  - The chosen entry goes to ISSUED; disp_idx and disp_valid are registered; rr_ptr = chosen+1 mod NUM_OC.
  - If nothing is READY, disp_valid=0 next cycle.
- Handshake: while disp_valid=1 & disp_ready=0, all disp_* outputs are held stable. On disp_valid & disp_ready, entry[disp_idx] returns to FREE at that clock edge and can be allocated the following cycle. The same edge may load the next READY entry, so back-to-back dispatch runs at 1 per cycle.
- Latency:
  - Last operand written at edge t -> READY after t -> disp_valid=1 after edge t+1, i.e. a minimum of 2 cycles.
  - An entry whose operands arrive back-to-back occupies the collector for at least 4 cycles.
- Simultaneous events:
  - Allocate, operand return and dispatch free in the same cycle are all honoured.
  - An entry freed at edge t is not visible to alloc_idx until after t.
  - A return addressed to an entry that is FREE or ISSUED counts as stray.
- free_cnt is the registered count of FREE entries and is updated every cycle.
- Reset asserted mid-operation discards all in-flight entries and any pending dispatch immediately.

Test Plan:
- Reset, then alloc two_src=1 warp=2 op=5 dst=3 -> alloc_idx=0, free_cnt=7. Return ocid=4'h0 data=A at edge t, ocid=4'h8 data=B at edge t+1. -> disp_valid=1 after edge t+2 with src1=A, src2=B, warp=2; disp_ready=1 -> free_cnt=8.
- Alloc single-source entry idx0, return ocid=4'h0 data=C -> dispatch with src2=0. A second return to ocid=4'h8 before dispatch -> data dropped, err_stray=1 and stays 1.
- Fill all 8 entries -> alloc_ready=0, free_cnt=0. Assert alloc_valid -> no state change. Dispatch one entry -> alloc_ready=1 the next cycle, with alloc_idx equal to the freed index.
- Entries 1, 3 and 6 READY together, disp_ready=1 -> dispatch order 1, 3, 6 on consecutive cycles. Then entries 0 and 6 READY with rr_ptr=7 -> order 0, 6.
- Hold disp_ready=0 for 5 cycles while other entries become READY -> disp_idx and data stay stable. Release -> next dispatch follows round-robin order.
- Pull rst low mid-dispatch with 3 entries in WAIT -> disp_valid=0 and free_cnt=8 immediately. A subsequent return to an old ocid -> err_stray=1.
